// File: rtl/disp_frame_scheduler.sv
// disp_frame_scheduler
//   Shares the four-digit LED display between the UART receive channel and
//   the local error/status source. A frame is accepted over a valid/ready
//   handshake and written one digit per cycle (digit 3 first). It then stays
//   displayed for at least HOLD_CYCLES before the next grant. When both
//   sources request, the source that was not granted last wins.
//
//   Optional feature macro: DISP_IDLE_BLANK_EN
//     When defined, IDLE_CYCLES idle cycles with no request blank the display
//     (four writes of 4'hF). This happens once per idle period.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   rx_valid/rx_frame    UART frame request (digit 3 in bits [15:12])
//   rx_ready             combinational accept for the UART source
//   err_valid/err_frame  error/status frame request
//   err_ready            combinational accept for the error source
//   wr_en/wr_addr/wr_char  registered digit write to the LED driver
//   busy                 registered, high in every state except IDLE
//   grant_src            registered, 0 = rx / 1 = err for the last accepted frame
module disp_frame_scheduler #(
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned IDLE_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [15:0] rx_frame,
    output logic        rx_ready,
    input  logic        err_valid,
    input  logic [15:0] err_frame,
    output logic        err_ready,
    output logic        wr_en,
    output logic [1:0]  wr_addr,
    output logic [3:0]  wr_char,
    output logic        busy,
    output logic        grant_src
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD
`ifdef DISP_IDLE_BLANK_EN
        , S_BLANK
`endif
    } state_t;

    state_t        state, state_n;
    logic [15:0]   frame, frame_n;
    logic [HW-1:0] hold_cnt, hold_cnt_n;
    logic          prefer_err, prefer_err_n;
    logic          grant_src_n;
    logic          wr_en_n;
    logic [1:0]    wr_addr_n;
    logic [3:0]    wr_char_n;
    logic          blank_wr;
    logic          sel_err, take;

`ifdef DISP_IDLE_BLANK_EN
    localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
    logic [IW-1:0] idle_cnt, idle_cnt_n;
    logic          blanked, blanked_n;
`endif

    // Arbitration: a lone request always wins. With both pending, the
    // round-robin pointer decides.
    always_comb begin
        sel_err   = err_valid && (!rx_valid || prefer_err);
        take      = (state == S_IDLE) && !reset && (rx_valid || err_valid);
        rx_ready  = take && !sel_err;
        err_ready = take && sel_err;
    end

    always_comb begin
        state_n      = state;
        frame_n      = frame;
        hold_cnt_n   = hold_cnt;
        prefer_err_n = prefer_err;
        grant_src_n  = grant_src;
        wr_en_n      = 1'b0;
        wr_addr_n    = '0;
        blank_wr     = 1'b0;
`ifdef DISP_IDLE_BLANK_EN
        idle_cnt_n   = idle_cnt;
        blanked_n    = blanked;
`endif
        case (state)
            S_IDLE: begin
                if (take) begin
                    state_n      = S_LOAD;
                    frame_n      = sel_err ? err_frame : rx_frame;
                    grant_src_n  = sel_err;
                    prefer_err_n = !sel_err;
                    wr_en_n      = 1'b1;
                    wr_addr_n    = 2'd3;
`ifdef DISP_IDLE_BLANK_EN
                    idle_cnt_n   = '0;
                    blanked_n    = 1'b0;
                end else if (!blanked) begin
                    if (idle_cnt == IW'(IDLE_CYCLES - 1)) begin
                        state_n    = S_BLANK;
                        wr_en_n    = 1'b1;
                        wr_addr_n  = 2'd3;
                        blank_wr   = 1'b1;
                        idle_cnt_n = '0;
                        blanked_n  = 1'b1;
                    end else begin
                        idle_cnt_n = idle_cnt + 1'b1;
                    end
`endif
                end
            end
            S_LOAD: begin
                if (wr_addr == 2'd0) begin
                    state_n    = S_HOLD;
                    hold_cnt_n = HW'(HOLD_CYCLES - 1);
                end else begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = wr_addr - 2'd1;
                end
            end
            S_HOLD: begin
                if (hold_cnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    hold_cnt_n = hold_cnt - 1'b1;
                end
            end
`ifdef DISP_IDLE_BLANK_EN
            S_BLANK: begin
                if (wr_addr == 2'd0) begin
                    state_n = S_IDLE;
                end else begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = wr_addr - 2'd1;
                    blank_wr  = 1'b1;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase

        // The character is registered together with its address, so it is
        // taken from the next-cycle frame/address.
        wr_char_n = (wr_en_n && !blank_wr) ? frame_n[{wr_addr_n, 2'b00} +: 4] : 4'hF;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            frame      <= '0;
            hold_cnt   <= '0;
            prefer_err <= 1'b1;
            grant_src  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_char    <= 4'hF;
            busy       <= 1'b0;
`ifdef DISP_IDLE_BLANK_EN
            idle_cnt   <= '0;
            blanked    <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            frame      <= frame_n;
            hold_cnt   <= hold_cnt_n;
            prefer_err <= prefer_err_n;
            grant_src  <= grant_src_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_char    <= wr_char_n;
            busy       <= (state_n != S_IDLE);
`ifdef DISP_IDLE_BLANK_EN
            idle_cnt   <= idle_cnt_n;
            blanked    <= blanked_n;
`endif
        end
    end

endmodule

// File: tb/tb_disp_frame_scheduler.sv
// Testbench for disp_frame_scheduler: directed scenarios with literal
// expectations plus randomized requests compared every cycle against a
// frame-level behavioural model.
module tb_disp_frame_scheduler;

    localparam int H  = 6;
    localparam int IC = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid, err_valid;
    logic [15:0] rx_frame, err_frame;
    logic        rx_ready, err_ready;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [3:0]  wr_char;
    logic        busy, grant_src;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    disp_frame_scheduler #(.HOLD_CYCLES(H), .IDLE_CYCLES(IC)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_frame  (rx_frame),
        .rx_ready  (rx_ready),
        .err_valid (err_valid),
        .err_frame (err_frame),
        .err_ready (err_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_char   (wr_char),
        .busy      (busy),
        .grant_src (grant_src)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a display "job" (frame or blank) occupies m_len
    // cycles, writing digits 3..0 during its first four cycles.
    int          m_len, m_pos, m_idle;
    logic [15:0] m_frame;
    bit          m_blank, m_pref, m_gsrc, m_blanked;

    always @(negedge clk) begin
        logic       e_busy, e_en, e_rr, e_er, want_err;
        logic [1:0] e_addr;
        logic [3:0] e_char;
        if (reset) begin
            m_len = 0; m_pos = 0; m_idle = 0; m_frame = '0;
            m_blank = 0; m_pref = 1; m_gsrc = 0; m_blanked = 0;
        end
        e_busy   = (m_len != 0);
        e_en     = e_busy && (m_pos < 4);
        e_addr   = e_en ? 2'(3 - m_pos) : 2'd0;
        e_char   = (!e_en || m_blank) ? 4'hF : 4'(m_frame >> (4 * (3 - m_pos)));
        want_err = err_valid && (!rx_valid || m_pref);
        e_rr     = !reset && !e_busy && rx_valid && !want_err;
        e_er     = !reset && !e_busy && want_err;

        check("model_rx_ready",  rx_ready,  e_rr);
        check("model_err_ready", err_ready, e_er);
        check("model_wr_en",     wr_en,     e_en);
        check("model_wr_addr",   wr_addr,   e_addr);
        check("model_wr_char",   wr_char,   e_char);
        check("model_busy",      busy,      e_busy);
        check("model_grant_src", grant_src, m_gsrc);
        if (rx_ready && err_ready) check("both_ready", 1, 0);

        if (!reset) begin
            if (e_busy) begin
                m_pos++;
                if (m_pos == m_len) m_len = 0;
            end else if (e_rr || e_er) begin
                m_len = 4 + H; m_pos = 0; m_blank = 0;
                m_frame = e_er ? err_frame : rx_frame;
                m_gsrc = e_er; m_pref = !e_er;
                m_idle = 0; m_blanked = 0;
            end else begin
`ifdef DISP_IDLE_BLANK_EN
                if (!m_blanked) begin
                    m_idle++;
                    if (m_idle == IC) begin
                        m_len = 4; m_pos = 0; m_blank = 1;
                        m_blanked = 1; m_idle = 0;
                    end
                end
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n, got, writes, nonf, first_wr;
        int         t[3];
        logic       src[3];
        logic       pr, pe;
        logic [1:0] exp_addr[4];
        logic [3:0] exp_char[4];
        exp_addr = '{2'd3, 2'd2, 2'd1, 2'd0};
        exp_char = '{4'h0, 4'h1, 4'h2, 4'h3};

        rx_valid = 0; err_valid = 0; rx_frame = '0; err_frame = '0;
        #100;
        @(posedge clk); #1 reset = 0; #1;
        check("rst_rx_ready", rx_ready, 0);
        check("rst_err_ready", err_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_char", wr_char, 4'hF);
        check("rst_busy", busy, 0);
        check("rst_grant_src", grant_src, 0);

        // Single rx frame
        tick();
        rx_valid = 1; rx_frame = 16'h0123; #1;
        check("single_rx_ready", rx_ready, 1);
        check("single_err_ready", err_ready, 0);
        tick();
        rx_valid = 0;
        for (int k = 0; k < 4; k++) begin
            check("single_wr_en", wr_en, 1);
            check("single_wr_addr", wr_addr, exp_addr[k]);
            check("single_wr_char", wr_char, exp_char[k]);
            check("single_busy", busy, 1);
            check("single_grant", grant_src, 0);
            tick();
        end
        n = 0;
        while (busy && n < 100) begin
            n++;
            check("hold_wr_en", wr_en, 0);
            check("hold_wr_char", wr_char, 4'hF);
            tick();
        end
        check("single_hold_len", n, H);
        check("single_idle_busy", busy, 0);

        // Contention: grants alternate, fixed spacing
        err_frame = 16'hEEEE; rx_frame = 16'h1111;
        err_valid = 1; rx_valid = 1; #1;
        got = 0;
        for (int c = 0; c < 200 && got < 3; c++) begin
            if (rx_ready || err_ready) begin
                src[got] = err_ready; t[got] = cyc; got++;
            end
            tick();
        end
        err_valid = 0; rx_valid = 0;
        check("cont_count", got, 3);
        check("cont_src0", src[0], 1);
        check("cont_src1", src[1], 0);
        check("cont_src2", src[2], 1);
        check("cont_gap01", t[1] - t[0], 5 + H);
        check("cont_gap12", t[2] - t[1], 5 + H);
        check("cont_char", wr_char, 4'hE);

        // Request raised mid-HOLD
        repeat (6) tick();
        rx_valid = 1; rx_frame = 16'hA5C3; #1;
        n = 0;
        while (busy && n < 50) begin
            n++;
            check("holdreq_no_ready", rx_ready, 0);
            tick();
        end
        check("holdreq_wait", n, H - 2);
        check("holdreq_idle", busy, 0);
        check("holdreq_ready", rx_ready, 1);
        tick();
        rx_valid = 0;
        check("holdreq_addr3", wr_addr, 2'd3);
        check("holdreq_char3", wr_char, 4'hA);

        // Reset during LOAD
        tick();
        check("midload_addr2", wr_addr, 2'd2);
        check("midload_char2", wr_char, 4'h5);
        tick();
        reset = 1; #1;
        check("midload_rst_wr_en", wr_en, 0);
        check("midload_rst_busy", busy, 0);
        check("midload_rst_char", wr_char, 4'hF);
        tick(); tick();
        reset = 0; #1;
        err_valid = 1; err_frame = 16'h9876; #1;
        check("rerequest_ready", err_ready, 1);
        tick();
        err_valid = 0;
        check("rerequest_addr", wr_addr, 2'd3);
        check("rerequest_char", wr_char, 4'h9);
        check("rerequest_grant", grant_src, 1);

        // Idle period after a frame
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
        writes = 0; nonf = 0; first_wr = -1;
        for (int c = 0; c < 40; c++) begin
            if (wr_en) begin
                writes++;
                if (first_wr < 0) first_wr = c;
                if (wr_char != 4'hF) nonf++;
            end
            tick();
        end
`ifdef DISP_IDLE_BLANK_EN
        check("blank_writes", writes, 4);
        check("blank_first", first_wr, IC);
`else
        check("noblank_writes", writes, 0);
`endif
        check("blank_chars", nonf, 0);

        // Randomized requests against the model
        for (int i = 0; i < 1500; i++) begin
            pr = rx_ready; pe = err_ready;
            tick();
            if (pr || (rx_valid && $urandom_range(0, 15) == 0)) rx_valid = 0;
            else if (!rx_valid && $urandom_range(0, 3) == 0) begin
                rx_valid = 1; rx_frame = 16'($urandom);
            end
            if (pe || (err_valid && $urandom_range(0, 15) == 0)) err_valid = 0;
            else if (!err_valid && $urandom_range(0, 5) == 0) begin
                err_valid = 1; err_frame = 16'($urandom);
            end
            #1;
        end
        rx_valid = 0; err_valid = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_frame_scheduler.md
# disp_frame_scheduler

Arbitrating scheduler that shares the four-digit LED display between two frame sources: the UART receive channel and the local error/status source. It accepts one 4-character frame (16 bits, digit 3 in bits [15:12]) per grant over a valid/ready handshake. It writes the frame into the LED driver's digit registers one digit per cycle, then holds it for a programmable minimum time before granting again. It sits between the UART receive path/status logic and the FourDigitLEDdriver/LEDdecoder pair.

## Interface
- HOLD_CYCLES, 1024, minimum cycles a frame stays displayed after loading; legal range ≥1
- IDLE_CYCLES, 4096, idle cycles before auto-blank; used only when DISP_IDLE_BLANK_EN is defined; legal range ≥1
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- rx_valid  in  1  UART frame request
- rx_frame  in  16  UART frame, 4 × 4-bit character codes
- rx_ready  out  1  UART frame accepted this cycle
- err_valid  in  1  error/status frame request
- err_frame  in  16  error/status frame
- err_ready  out  1  error frame accepted this cycle
- wr_en  out  1  digit write strobe to LED driver
- wr_addr  out  2  digit index (3 = an3 … 0 = an0)
- wr_char  out  4  character code for addressed digit
- busy  out  1  high in any state other than IDLE
- grant_src  out  1  source of the frame last accepted (0 = rx, 1 = err)

## Operation
- States: IDLE, LOAD, HOLD; BLANK is added when DISP_IDLE_BLANK_EN is defined.
- **IDLE:** if any valid is high, select one requester and assert only its ready, combinationally, in the same cycle. The transfer occurs on that edge: latch the frame, update grant_src, go to LOAD with wr_addr starting at 3.
- **Arbitration:** a single request is always granted. If both are valid, the source not granted last wins (round-robin). After reset, the pointer favours err.
- Requesters hold valid and frame stable until ready. Valid dropping without ready is permitted; no transfer occurs.
- **LOAD:** 4 cycles, wr_en=1. wr_addr = 3, 2, 1, 0 on consecutive cycles, with wr_char = latched_frame[4*wr_addr+3 : 4*wr_addr]. After addr 0, go to HOLD.
- **HOLD:** counter width $clog2(HOLD_CYCLES+1), loaded with HOLD_CYCLES-1, decrements each cycle. At 0, go to IDLE. No ready is asserted during LOAD or HOLD; requests wait.
- Both readys are never high in the same cycle. No ready is asserted outside IDLE.
- **Reset (any state, mid-LOAD included):** immediately IDLE; partially written digits are not restored.
- **Reset values:** rx_ready=0, err_ready=0, wr_en=0, wr_addr=2'd0, wr_char=4'hF, busy=0, grant_src=0; RR pointer favours err.

## Timing
- Accept edge → first wr_en cycle: 1 cycle (state register updates on the accept edge).
- A frame occupies 4 LOAD + HOLD_CYCLES cycles after acceptance. The next ready is asserted no earlier than cycle 5+HOLD_CYCLES after the accept edge.
- wr_en, wr_addr, wr_char, busy, and grant_src are registered. rx_ready and err_ready are combinational from state and the valids.
- wr_char equals 4'hF whenever wr_en=0.

## Configuration
- **DISP_IDLE_BLANK_EN defined:**
  - An idle counter runs in IDLE and clears on any accept.
  - After IDLE_CYCLES consecutive idle cycles with no valid, enter BLANK: 4 write cycles (addr 3..0, wr_char=4'hF), then IDLE with the counter cleared. Blanking fires once per idle period.
  - A valid arriving during BLANK waits until BLANK completes.
- **Not defined:** no idle counter and no BLANK state; the last frame stays displayed indefinitely.

## Test plan
- **Reset:** reset=1 for 100 ns, release → all outputs at reset values, busy=0.
- **Single rx:** rx_valid=1, rx_frame=16'h0123 → rx_ready for 1 cycle. Next 4 cycles: (addr,char) = (3,0),(2,1),(1,2),(0,3). busy=1 for 4+HOLD_CYCLES cycles.
- **Contention:** both valid continuously, err=16'hEEEE, rx=16'h1111 → grants alternate err, rx, err. Each successive accept is exactly 5+HOLD_CYCLES cycles apart. Readys are never simultaneously high.
- **Request during HOLD:** rx_valid raised mid-HOLD → no ready until IDLE, then accepted on the first IDLE cycle.
- **Reset mid-LOAD:** assert reset after the addr-2 write → wr_en=0 and state IDLE immediately. A re-request after release restarts at addr 3.
- **Idle blank (DISP_IDLE_BLANK_EN, IDLE_CYCLES=8):** no requests for 8 cycles after HOLD → 4 writes of 4'hF. With the macro undefined, the same stimulus produces no writes.
